// File: rtl/uart_fifo_core.sv
// uart_fifo_core: memory-mapped 8N1 UART with TX/RX FIFOs and a level interrupt.
// Bus accesses are granted combinationally and answered one cycle after the grant.

module uart_fifo_core_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// state    | meaning (TX and RX machines share the encoding)
// ST_IDLE  | line idle; TX waits for FIFO data, RX waits for a falling edge
// ST_START | start bit; RX re-samples at half a bit to reject glitches
// ST_DATA  | eight data bits, LSB first
// ST_STOP  | stop bit; TX may chain straight into the next frame
module uart_fifo_core #(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned BAUD_RATE  = 57600,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        irq_o
);
  localparam logic [15:0] DIV_RST    = 16'(CLK_FREQ / BAUD_RATE);
  localparam logic [15:0] DIV_MIN    = 16'd16;
  localparam logic [1:0]  REG_TXDATA = 2'd0;
  localparam logic [1:0]  REG_RXDATA = 2'd1;
  localparam logic [1:0]  REG_STATUS = 2'd2;
  localparam logic [1:0]  REG_CTRL   = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  logic [15:0] divisor;
  logic        rx_irq_en;
  logic        tx_irq_en;
  logic        rx_overrun;
  logic        frame_err;

  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_head;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;

  logic [1:0]  reg_sel;
  logic        wr_en, rd_en;
  logic [31:0] rd_mux;

  uart_state_t tx_state;
  logic [15:0] tx_div, tx_timer;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;
  logic        tx_tc, tx_busy;

  uart_state_t rx_state;
  logic [15:0] rx_div, rx_timer;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic        rx_tc;
  logic        rx_meta, rx_sync, rx_prev, rx_fall;
  logic        rx_stop_tc, rx_byte_ok, overrun_set, frame_err_set;

  logic        unused_bits;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:18], BASE_ADDR};

  uart_fifo_core_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(tx_push), .push_data(wdata_i[7:0]),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo_core_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(rx_push), .push_data(rx_shift),
    .pop(rx_pop), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  assign reg_sel = addr_i[3:2];
  assign gnt_o   = req_i && !(we_i && (reg_sel == REG_TXDATA) && tx_full);
  assign wr_en   = gnt_o && we_i;
  assign rd_en   = gnt_o && !we_i;
  assign tx_push = wr_en && (reg_sel == REG_TXDATA);
  assign rx_pop  = rd_en && (reg_sel == REG_RXDATA);

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_RXDATA: rd_mux = rx_empty ? 32'h8000_0000 : {24'h0, rx_head};
      REG_STATUS: rd_mux = {25'h0, frame_err, tx_busy, rx_overrun,
                            rx_empty, rx_full, tx_empty, tx_full};
      REG_CTRL:   rd_mux = {14'h0, tx_irq_en, rx_irq_en, divisor};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= gnt_o;
      rdata_o  <= rd_en ? rd_mux : '0;
    end
  end

  // Configuration, sticky flags and the registered interrupt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      divisor    <= DIV_RST;
      rx_irq_en  <= 1'b0;
      tx_irq_en  <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      if (wr_en && (reg_sel == REG_CTRL)) begin
        divisor   <= (wdata_i[15:0] < DIV_MIN) ? DIV_MIN : wdata_i[15:0];
        rx_irq_en <= wdata_i[16];
        tx_irq_en <= wdata_i[17];
      end
      if (wr_en && (reg_sel == REG_STATUS) && wdata_i[4]) rx_overrun <= 1'b0;
      if (wr_en && (reg_sel == REG_STATUS) && wdata_i[6]) frame_err  <= 1'b0;
      if (overrun_set)   rx_overrun <= 1'b1;
      if (frame_err_set) frame_err  <= 1'b1;
      irq_o <= (rx_irq_en && !rx_empty) || (tx_irq_en && tx_empty) || rx_overrun || frame_err;
    end
  end

  assign tx_tc   = (tx_timer == '0);
  assign tx_busy = (tx_state != ST_IDLE);
  assign tx_pop  = !tx_empty && ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && tx_tc));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state <= ST_IDLE;
      tx_o     <= 1'b1;
      tx_div   <= DIV_RST;
      tx_timer <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (!tx_empty) begin
            tx_state <= ST_START;
            tx_o     <= 1'b0;
            tx_shift <= tx_head;
            tx_div   <= divisor;
            tx_timer <= divisor - 1'b1;
          end
        end
        ST_START: begin
          if (tx_tc) begin
            tx_state <= ST_DATA;
            tx_o     <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= '0;
            tx_timer <= tx_div - 1'b1;
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_tc) begin
            tx_timer <= tx_div - 1'b1;
            if (tx_bit == 3'd7) begin
              tx_state <= ST_STOP;
              tx_o     <= 1'b1;
            end else begin
              tx_o     <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        ST_STOP: begin
          // Chain directly into the next start bit when more data is queued.
          if (tx_tc) begin
            if (!tx_empty) begin
              tx_state <= ST_START;
              tx_o     <= 1'b0;
              tx_shift <= tx_head;
              tx_div   <= divisor;
              tx_timer <= divisor - 1'b1;
            end else begin
              tx_state <= ST_IDLE;
            end
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // Synchroniser resets low so a line already low at reset release never looks like an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall       = rx_prev && !rx_sync;
  assign rx_tc         = (rx_timer == '0);
  assign rx_stop_tc    = (rx_state == ST_STOP) && rx_tc;
  assign rx_byte_ok    = rx_stop_tc && rx_sync;
  assign rx_push       = rx_byte_ok && (!rx_full || rx_pop);
  assign overrun_set   = rx_byte_ok && rx_full && !rx_pop;
  assign frame_err_set = rx_stop_tc && !rx_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state <= ST_IDLE;
      rx_div   <= DIV_RST;
      rx_timer <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (rx_fall) begin
            rx_state <= ST_START;
            rx_div   <= divisor;
            rx_timer <= (divisor >> 1) - 1'b1;
          end
        end
        ST_START: begin
          if (rx_tc) begin
            if (rx_sync) begin
              rx_state <= ST_IDLE;
            end else begin
              rx_state <= ST_DATA;
              rx_timer <= rx_div - 1'b1;
              rx_bit   <= '0;
            end
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_tc) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_timer <= rx_div - 1'b1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_tc) rx_state <= ST_IDLE;
          else       rx_timer <= rx_timer - 1'b1;
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: register access, loopback, back-pressure,
// overrun, glitch/framing and reset-mid-frame scenarios with hand-computed expectations.
module tb_uart_fifo_core;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_TX   = BASE + 32'h0;
  localparam logic [31:0] A_RX   = BASE + 32'h4;
  localparam logic [31:0] A_ST   = BASE + 32'h8;
  localparam logic [31:0] A_CTRL = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        rx_i, tx_o, irq;
  logic        rx_drv, loopback;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_cnt = 0;

  assign rx_i = loopback ? tx_o : rx_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  uart_fifo_core #(
    .CLK_FREQ(25_000_000), .BAUD_RATE(57600), .FIFO_DEPTH(4), .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .rx_i(rx_i), .tx_o(tx_o), .irq_o(irq)
  );

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic rv);
    int waited = 0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    #1;
    while (!gnt && waited < 2000) begin
      @(negedge clk); #1; waited++;
    end
    if (!gnt) begin
      checks++; errors++;
      $display("FAIL bus_grant_timeout addr=%h", a);
      req = 1'b0; rd = '0; rv = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    rd = rdata; rv = rvalid;
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; logic rv;
    bus(1'b1, a, d, rd, rv);
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] rd);
    logic rv;
    bus(1'b0, a, 32'h0, rd, rv);
  endtask

  task automatic send_rx(input logic [7:0] b, input int div, input logic stop);
    rx_drv = 1'b0; repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i]; repeat (div) @(negedge clk);
    end
    rx_drv = stop; repeat (div) @(negedge clk);
    rx_drv = 1'b1; repeat (div) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1; req = 1'b1; we = 1'b1; addr = A_TX; wdata = 32'h0;
    rx_drv = 1'b1; loopback = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx_o got %b expected 1", tx_o); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b expected 0", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h expected 0", rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b expected 0", irq); end
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt got %b expected 1", gnt); end
    req = 1'b0;
    @(negedge clk); rst = 1'b0;
    reg_read(A_ST, rd);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL reset_status got %h expected 0000000a", rd); end
    reg_read(A_CTRL, rd);
    checks++; if (rd !== 32'h0000_01B2) begin errors++; $display("FAIL reset_ctrl got %h expected 000001b2", rd); end
  endtask

  task automatic test_regs();
    logic [31:0] rd; logic rv;
    bus(1'b1, A_CTRL, 32'h0000_0005, rd, rv);
    checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL write_response got rvalid=%b rdata=%h expected 1/0", rv, rd); end
    reg_read(A_CTRL, rd);
    checks++; if (rd !== 32'h0000_0010) begin errors++; $display("FAIL div_saturate got %h expected 00000010", rd); end
    reg_write(A_CTRL, 32'h0002_0123);
    reg_read(32'hABCD_EF0F, rd);
    checks++; if (rd !== 32'h0002_0123) begin errors++; $display("FAIL ctrl_alias got %h expected 00020123", rd); end
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tx_irq got %b expected 1", irq); end
    bus(1'b0, A_TX, 32'h0, rd, rv);
    checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL txdata_read got rvalid=%b rdata=%h expected 1/0", rv, rd); end
    reg_write(A_RX, 32'h0000_0055);
    reg_read(A_ST, rd);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL rxdata_write_status got %h expected 0000000a", rd); end
    reg_write(A_CTRL, 32'h0000_0010);
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_off got %b expected 0", irq); end
  endtask

  task automatic test_loopback();
    logic [31:0] rd;
    int unsigned t0;
    reg_write(A_CTRL, 32'h0001_0010);
    loopback = 1'b1;
    reg_write(A_TX, 32'h0000_0055);
    reg_write(A_TX, 32'h0000_00A3);
    t0 = cyc_cnt; rd = 32'h8;
    while (rd[3] && (cyc_cnt - t0) <= 328) reg_read(A_ST, rd);
    checks++; if (rd[3] !== 1'b0) begin errors++; $display("FAIL loop_rx_arrival got rx_empty=%b expected 0 within 328 cycles", rd[3]); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL loop_rx_irq got %b expected 1", irq); end
    reg_read(A_RX, rd);
    checks++; if (rd !== 32'h0000_0055) begin errors++; $display("FAIL loop_byte0 got %h expected 00000055", rd); end
    t0 = cyc_cnt; rd = 32'h8;
    while (rd[3] && (cyc_cnt - t0) <= 400) reg_read(A_ST, rd);
    reg_read(A_RX, rd);
    checks++; if (rd !== 32'h0000_00A3) begin errors++; $display("FAIL loop_byte1 got %h expected 000000a3", rd); end
    reg_read(A_RX, rd);
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL loop_empty_read got %h expected 80000000", rd); end
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL loop_irq_clear got %b expected 0", irq); end
    loopback = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  data [6];
    int          gnt_cyc [6];
    logic        tx_samp [200];
    logic [7:0]  frame0;
    logic [31:0] rd;
    int          issued = 0;
    int unsigned t0;
    for (int i = 0; i < 6; i++) begin data[i] = 8'h11 + 8'(i); gnt_cyc[i] = -1; end
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (issued < 6) begin req = 1'b1; we = 1'b1; addr = A_TX; wdata = {24'h0, data[issued]}; end
      else req = 1'b0;
      #1;
      tx_samp[cyc] = tx_o;
      if (req && gnt) begin gnt_cyc[issued] = cyc; issued++; end
    end
    req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (gnt_cyc[i] !== i) begin errors++; $display("FAIL b2b_grant%0d got cycle %0d expected %0d", i, gnt_cyc[i], i); end
    end
    checks++; if (gnt_cyc[5] !== 162) begin errors++; $display("FAIL b2b_grant5 got cycle %0d expected 162", gnt_cyc[5]); end
    checks++; if (tx_samp[1] !== 1'b1 || tx_samp[2] !== 1'b0) begin errors++; $display("FAIL b2b_first_start got %b%b expected 10", tx_samp[1], tx_samp[2]); end
    checks++; if (tx_samp[161] !== 1'b1 || tx_samp[162] !== 1'b0) begin errors++; $display("FAIL b2b_no_gap got %b%b expected 10", tx_samp[161], tx_samp[162]); end
    for (int i = 0; i < 8; i++) frame0[i] = tx_samp[26 + 16*i];
    checks++; if (frame0 !== 8'h11) begin errors++; $display("FAIL b2b_frame0 got %h expected 11", frame0); end
    t0 = cyc_cnt; rd = 32'h20;
    while (rd[5] && (cyc_cnt - t0) <= 1500) reg_read(A_ST, rd);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL b2b_drain got %h expected 0000000a", rd); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    for (int i = 0; i < 5; i++) send_rx(8'h31 + 8'(i), 16, 1'b1);
    reg_read(A_ST, rd);
    checks++; if (rd !== 32'h0000_0016) begin errors++; $display("FAIL ovr_status got %h expected 00000016", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovr_irq got %b expected 1", irq); end
    for (int i = 0; i < 4; i++) begin
      reg_read(A_RX, rd);
      checks++; if (rd !== {24'h0, 8'h31 + 8'(i)}) begin errors++; $display("FAIL ovr_read%0d got %h expected %h", i, rd, 8'h31 + 8'(i)); end
    end
    reg_read(A_ST, rd);
    checks++; if (rd !== 32'h0000_001A) begin errors++; $display("FAIL ovr_sticky got %h expected 0000001a", rd); end
    reg_write(A_ST, 32'h0000_0010);
    reg_read(A_ST, rd);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL ovr_clear got %h expected 0000000a", rd); end
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovr_irq_clear got %b expected 0", irq); end
  endtask

  task automatic test_glitch_framing();
    logic [31:0] rd;
    reg_write(A_CTRL, 32'h0000_0020);
    rx_drv = 1'b0; repeat (4) @(negedge clk);
    rx_drv = 1'b1; repeat (100) @(negedge clk);
    reg_read(A_ST, rd);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL glitch_status got %h expected 0000000a", rd); end
    send_rx(8'hA5, 32, 1'b0);
    reg_read(A_ST, rd);
    checks++; if (rd !== 32'h0000_004A) begin errors++; $display("FAIL frame_err_status got %h expected 0000004a", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL frame_err_irq got %b expected 1", irq); end
    reg_write(A_ST, 32'h0000_0040);
    reg_read(A_ST, rd);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL frame_err_clear got %h expected 0000000a", rd); end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] rd;
    int waited = 0;
    reg_write(A_CTRL, 32'h0000_0010);
    send_rx(8'h66, 16, 1'b1);
    reg_write(A_TX, 32'h0000_0000);
    reg_write(A_TX, 32'h0000_0077);
    reg_write(A_TX, 32'h0000_0078);
    // The first write is already in flight; find the start bit from the line itself.
    while (tx_o !== 1'b0 && waited < 100) begin @(negedge clk); waited++; end
    checks++; if (tx_o !== 1'b0) begin errors++; $display("FAIL rst_mid_start got tx_o=%b expected 0", tx_o); end
    repeat (72 - 4) @(negedge clk);
    reg_read(A_ST, rd);
    checks++; if (rd !== 32'h0000_0020 || tx_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got status=%h tx_o=%b expected 00000020/0", rd, tx_o); end
    rst = 1'b1;
    #1;
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL rst_mid_tx_o got %b expected 1", tx_o); end
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rvalid !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs got rvalid=%b rdata=%h irq=%b expected 0/0/0", rvalid, rdata, irq); end
    rst = 1'b0;
    reg_read(A_ST, rd);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL rst_mid_status got %h expected 0000000a", rd); end
    reg_read(A_CTRL, rd);
    checks++; if (rd !== 32'h0000_01B2) begin errors++; $display("FAIL rst_mid_ctrl got %h expected 000001b2", rd); end
    repeat (4500) @(negedge clk);
    reg_read(A_ST, rd);
    checks++; if (rd !== 32'h0000_000A || tx_o !== 1'b1) begin errors++; $display("FAIL rst_low_line got status=%h tx_o=%b expected 0000000a/1", rd, tx_o); end
    rx_drv = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_regs();
    test_loopback();
    test_back_to_back();
    test_overrun();
    test_glitch_framing();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_fifo_core.md
UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
REQ-001 Parameter CLK_FREQ, default 25_000_000, is the clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 57600, sets the reset value of the divisor: DIV_RST = CLK_FREQ/BAUD_RATE, integer division.
REQ-003 Parameter FIFO_DEPTH, default 16, is the depth of each of the TX and RX FIFOs; it SHALL be a power of 2 and at least 2.
REQ-004 Parameter BASE_ADDR, default 32'h1000_0000, is the base address of the register block.
REQ-005 clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 req_i, input, 1 bit: bus request.
REQ-008 we_i, input, 1 bit: 1 = write, 0 = read.
REQ-009 addr_i, input, 32 bits: byte address.
REQ-010 wdata_i, input, 32 bits: write data.
REQ-011 gnt_o, output, 1 bit: request accepted, combinational in the same cycle as req_i.
REQ-012 rvalid_o, output, 1 bit: response valid, asserted for 1 cycle.
REQ-013 rdata_o, output, 32 bits: read data, valid only while rvalid_o=1.
REQ-014 rx_i, input, 1 bit: serial receive line, asynchronous to clk_i.
REQ-015 tx_o, output, 1 bit: serial transmit line.
REQ-016 irq_o, output, 1 bit: level interrupt.

Function
REQ-017 The register map, by offset from BASE_ADDR:
- 0x0 TXDATA, write only; wdata_i[7:0] is pushed to the TX FIFO.
- 0x4 RXDATA, read only; pops the RX FIFO.
- 0x8 STATUS: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 rx_overrun (sticky), bit5 tx_busy, bit6 frame_err (sticky); writing 1 to bit4 or bit6 clears that bit.
- 0xC CTRL, read/write: [15:0] divisor, bit16 rx_irq_en, bit17 tx_irq_en.
REQ-018 Register decode uses addr_i[3:2] only; addr_i[1:0] and the upper address bits are ignored.
REQ-019 gnt_o SHALL equal req_i, except that gnt_o=0 for a TXDATA write while the TX FIFO is full; the requester holds req_i until granted.
REQ-020 Every granted access produces rvalid_o=1 exactly 1 cycle after the grant; rdata_o=0 for writes.
REQ-021 Back-to-back granted accesses are supported, one per cycle.
REQ-022 A RXDATA read returns {24'h0, byte} when the RX FIFO is non-empty; when it is empty the read returns 32'h8000_0000 and no pop occurs.
REQ-023 Writes to read-only fields and reads of TXDATA have no side effect; such reads return 0.
REQ-024 A divisor write with value < 16 is saturated to 16.
REQ-025 Each bit period is `divisor` clk_i cycles.
REQ-026 Frame format is 8N1, LSB first, idle line high.
REQ-027 The TX state machine has states IDLE, START, DATA(8), STOP.
- IDLE to START when the TX FIFO is non-empty; the pop happens in that cycle.
- STOP returns to IDLE after 1 bit period.
- If the TX FIFO is non-empty at the end of STOP, the next frame starts with no idle gap.
REQ-028 tx_busy=1 in every TX state except IDLE.
REQ-029 rx_i SHALL pass through a 2-flop synchroniser before any use.
REQ-030 The RX state machine has states IDLE, START, DATA, STOP.
- IDLE to START on a falling edge of the synchronised rx_i.
- In START, rx_i is re-sampled at divisor/2; if it is high the frame is a glitch and the state returns to IDLE.
- Each data bit and the stop bit are sampled at the middle of its bit period.
REQ-031 When the stop bit is sampled 0, the byte is discarded and frame_err is set.
REQ-032 When a valid byte arrives with the RX FIFO full, the byte is discarded, rx_overrun is set and the FIFO contents are unchanged.
REQ-033 When a push and a pop hit the same FIFO in the same cycle, both occur; when full with a simultaneous pop, the push is accepted.
REQ-034 FIFO pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a count of width log2(FIFO_DEPTH)+1.
REQ-035 irq_o = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty) | rx_overrun | frame_err, registered.
REQ-036 A CTRL divisor change takes effect at the next frame start; a frame already in progress completes with the old divisor.

Reset
REQ-037 While rst_i=1, the outputs SHALL be: tx_o=1, gnt_o follows REQ-019 with FIFOs empty, rvalid_o=0, rdata_o=0, irq_o=0.
REQ-038 Reset puts both FIFOs empty and both state machines in IDLE.
REQ-039 Reset clears the sticky flags, sets divisor=DIV_RST and sets both irq enables to 0.
REQ-040 Reset asserted mid-frame aborts the frame immediately; tx_o goes to 1 asynchronously.
REQ-041 After rst_i deasserts, an rx_i already low does not start a frame until a falling edge is seen.

Verification
REQ-042 Loopback: with divisor=16, write 0x55 then 0xA3 to TXDATA with tx_o tied to rx_i.
- Required: after ≤ 2*10*16+8 cycles, STATUS.rx_empty=0.
- Required: RXDATA reads return 0x55, then 0xA3, then 32'h8000_0000.
REQ-043 TX back-pressure: with FIFO_DEPTH=4, issue 6 TXDATA writes.
- Required: the first 5 are granted immediately (1 pops into the shifter).
- Required: the 6th is granted only after the first frame's STOP completes.
- Required: tx_o shows no idle gap between frames.
REQ-044 RX overrun: drive FIFO_DEPTH+1 frames on rx_i without reading.
- Required: rx_full=1, rx_overrun=1 and irq_o=1.
- Required: the reads return the first FIFO_DEPTH bytes in order.
- Required: writing 0x10 to STATUS clears rx_overrun.
REQ-045 Glitch and framing error:
- A 4-cycle low pulse on rx_i at divisor=32 produces no byte.
- A frame with stop bit 0 sets frame_err, and rx_empty stays 1.
REQ-046 Reset mid-transmit: assert rst_i during DATA bit 3.
- Required: tx_o=1 within the same cycle, both FIFOs are empty, CTRL reads 0x0000_01B2 (CLK_FREQ=25 MHz, BAUD_RATE=57600).
